// File: rtl/ras_driver_pkg.sv
// ras_driver_pkg: shared types and MIPS opcode constants for the RAS driver.
package ras_driver_pkg;
    typedef logic [31:0] addr_t;
    typedef enum logic [1:0] {CTI_NONE, CTI_CALL, CTI_RET, CTI_CALLR} cti_kind_e;
    localparam logic [1:0] IDLE = 2'd0, WAIT_DS = 2'd1, REDIR = 2'd2;
    localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_JAL = 6'b000011;
    localparam logic [5:0] FN_JR = 6'b001000, FN_JALR = 6'b001001;
endpackage

// File: rtl/ras_driver_if.sv
// ras_driver_if: fetch bundle, RAS and redirect signals of the RAS driver.
interface ras_driver_if;
    import ras_driver_pkg::*;
    logic flush, in_valid, in_ready, in_valid1;
    addr_t in_pc;
    logic [31:0] in_instr0, in_instr1;
    logic ras_push, ras_pop;
    addr_t ras_ret_pc_push, ras_ret_pc_pop;
    logic redir_valid, redir_ready;
    addr_t redir_pc;
    modport slave (
        input flush, in_valid, in_pc, in_instr0, in_instr1, in_valid1, ras_ret_pc_pop, redir_ready,
        output in_ready, ras_push, ras_pop, ras_ret_pc_push, redir_valid, redir_pc
    );
    modport master (
        output flush, in_valid, in_pc, in_instr0, in_instr1, in_valid1, ras_ret_pc_pop, redir_ready,
        input in_ready, ras_push, ras_pop, ras_ret_pc_push, redir_valid, redir_pc
    );
endinterface

// File: rtl/ras_driver_cti_predecode.sv
// ras_driver_cti_predecode: classifies one instruction as call/return and computes the jal target.
// RAS_DRIVER_JALR_PUSH_EN enables decoding jalr rd==RA_REG as a push-only call.
module ras_driver_cti_predecode import ras_driver_pkg::*; #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  addr_t       pc,
    input  logic [31:0] instr,
    output cti_kind_e   kind,
    output addr_t       target
);
`ifdef RAS_DRIVER_JALR_PUSH_EN
    localparam logic JALR_EN = 1'b1;
`else
    localparam logic JALR_EN = 1'b0;
`endif
    logic [3:0] seg;
    logic is_jal, is_jr, is_jalr, special;
    always_comb begin
        seg = 4'((pc + 32'd4) >> 28);
        target = {seg, instr[25:0], 2'b00};
        special = instr[31:26] == OP_SPECIAL && instr[10:6] == 5'd0 && instr[20:16] == 5'd0;
        is_jal = instr[31:26] == OP_JAL;
        is_jr = special && instr[5:0] == FN_JR && instr[25:21] == RA_REG && instr[15:11] == 5'd0;
        is_jalr = special && instr[5:0] == FN_JALR && instr[15:11] == RA_REG;
        kind = is_jal ? CTI_CALL : is_jr ? CTI_RET : (JALR_EN && is_jalr) ? CTI_CALLR : CTI_NONE;
    end
endmodule

// File: rtl/ras_driver.sv
// ras_driver: predecodes fetch bundles, drives RAS push/pop and redirects fetch after the delay slot.
// RAS_DRIVER_JALR_PUSH_EN (see predecode) adds push-only jalr calls.
module ras_driver import ras_driver_pkg::*; #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input logic          clk,
    input logic          resetn,
    ras_driver_if.slave  bus
);
    logic [1:0] state_q, state_d;
    addr_t target_q, target_d;
    addr_t pc1, tgt0, tgt1, sel_pc, sel_tgt;
    cti_kind_e kind0, kind1, sel_kind;
    logic in_ready, accept, decode, cti0, cti1, redirect;
    assign pc1 = bus.in_pc + 32'd4;
    ras_driver_cti_predecode #(.RA_REG(RA_REG)) u_pd0 (
        .pc(bus.in_pc), .instr(bus.in_instr0), .kind(kind0), .target(tgt0)
    );
    ras_driver_cti_predecode #(.RA_REG(RA_REG)) u_pd1 (
        .pc(pc1), .instr(bus.in_instr1), .kind(kind1), .target(tgt1)
    );
    always_comb begin
        in_ready = state_q != REDIR;
        accept = bus.in_valid && in_ready && !bus.flush;
        decode = accept && state_q == IDLE;
        cti0 = kind0 != CTI_NONE;
        cti1 = bus.in_valid1 && kind1 != CTI_NONE;
        // the first CTI wins; anything after it is its delay slot
        sel_kind = cti0 ? kind0 : cti1 ? kind1 : CTI_NONE;
        sel_pc = cti0 ? bus.in_pc : pc1;
        sel_tgt = sel_kind == CTI_RET ? bus.ras_ret_pc_pop : cti0 ? tgt0 : tgt1;
        redirect = decode && (sel_kind == CTI_CALL || sel_kind == CTI_RET);
        target_d = redirect ? sel_tgt : target_q;
        state_d = bus.flush ? IDLE
                : redirect ? (cti0 && bus.in_valid1 ? REDIR : WAIT_DS)
                : (state_q == WAIT_DS && accept) ? REDIR
                : (state_q == REDIR && bus.redir_ready) ? IDLE
                : state_q;
        bus.in_ready = in_ready;
        bus.ras_push = decode && (sel_kind == CTI_CALL || sel_kind == CTI_CALLR);
        bus.ras_pop = decode && sel_kind == CTI_RET;
        bus.ras_ret_pc_push = sel_pc + 32'd8;
        bus.redir_valid = state_q == REDIR;
        bus.redir_pc = target_q;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            target_q <= target_d;
        end
    end
endmodule

// File: tb/tb_ras_driver.sv
// tb_ras_driver: directed scoreboard bench for ras_driver.
module tb_ras_driver;
    import ras_driver_pkg::*;
    localparam logic [31:0] NOP = 32'h0;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    ras_driver_if bus();
    ras_driver dut (.clk(clk), .resetn(resetn), .bus(bus));
    always #5 clk = ~clk;

    typedef struct { logic is_pop; logic [31:0] v; } ev_t;
    ev_t q[$];
    logic [31:0] rq[$];
    int n_assert = 0;
    int n_fail = 0;
    logic prev_rv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        ev_t e;
        logic ep, eo;
        ep = q.size() > 0 && !q[0].is_pop;
        eo = q.size() > 0 && q[0].is_pop;
        chk("ras_push", 32'(bus.ras_push), 32'(ep));
        chk("ras_pop", 32'(bus.ras_pop), 32'(eo));
        if (q.size() > 0) begin
            e = q.pop_front();
            if (!e.is_pop) chk("push_pc", bus.ras_ret_pc_push, e.v);
        end
        if (bus.redir_valid === 1'b1 && !prev_rv) begin
            chk("redir_expected", 32'(rq.size()), 32'd1);
            if (rq.size() > 0) chk("redir_pc", bus.redir_pc, rq.pop_front());
        end
        prev_rv = bus.redir_valid === 1'b1;
    endtask

    task automatic cyc();
        #1 mon();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] i0,
                         input logic [31:0] i1, input logic v1, input logic fl);
        bus.in_valid = v;
        bus.in_pc = pc;
        bus.in_instr0 = i0;
        bus.in_instr1 = i1;
        bus.in_valid1 = v1;
        bus.flush = fl;
    endtask

    task automatic idle_chk(input logic rv, input logic rdy);
        drive(1'b0, 32'h0, NOP, NOP, 1'b0, 1'b0);
        chk("redir_valid", 32'(bus.redir_valid), 32'(rv));
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        cyc();
    endtask

    initial begin
        drive(1'b0, 32'h0, NOP, NOP, 1'b0, 1'b0);
        bus.redir_ready = 1'b1;
        bus.ras_ret_pc_pop = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_redir_valid", 32'(bus.redir_valid), 32'd0);
        chk("rst_redir_pc", bus.redir_pc, 32'h0);
        chk("rst_push", 32'(bus.ras_push), 32'd0);
        chk("rst_pop", 32'(bus.ras_pop), 32'd0);
        resetn = 1'b1;
        repeat (5) idle_chk(1'b0, 1'b1);

        // jal in slot0 with delay slot present
        drive(1'b1, 32'h8000_0000, 32'h0C10_0000, NOP, 1'b1, 1'b0);
        q.push_back('{1'b0, 32'h8000_0008});
        rq.push_back(32'h8040_0000);
        cyc();
        idle_chk(1'b1, 1'b0);
        idle_chk(1'b0, 1'b1);

        // jal in slot1, delay slot arrives in the next bundle
        drive(1'b1, 32'h8000_0010, NOP, 32'h0C10_0004, 1'b1, 1'b0);
        q.push_back('{1'b0, 32'h8000_001C});
        cyc();
        chk("wait_ds_rv", 32'(bus.redir_valid), 32'd0);
        chk("wait_ds_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 32'h8000_0018, NOP, 32'h0C10_0008, 1'b1, 1'b0);
        rq.push_back(32'h8040_0010);
        cyc();
        idle_chk(1'b1, 1'b0);
        idle_chk(1'b0, 1'b1);

        // jr $31 pops and redirects to the sampled RAS top
        bus.ras_ret_pc_pop = 32'h8000_0008;
        drive(1'b1, 32'h8000_0020, 32'h03E0_0008, NOP, 1'b1, 1'b0);
        q.push_back('{1'b1, 32'h0});
        rq.push_back(32'h8000_0008);
        cyc();
        bus.ras_ret_pc_pop = 32'hDEAD_BEE0;
        idle_chk(1'b1, 1'b0);
        idle_chk(1'b0, 1'b1);

        // flush in WAIT_DS discards the pending redirect
        drive(1'b1, 32'h8000_0030, 32'h0C10_0010, NOP, 1'b0, 1'b0);
        q.push_back('{1'b0, 32'h8000_0038});
        cyc();
        drive(1'b1, 32'h8000_0038, NOP, NOP, 1'b1, 1'b1);
        chk("flush_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        repeat (3) idle_chk(1'b0, 1'b1);
        drive(1'b1, 32'h8000_0040, 32'h0C10_0010, NOP, 1'b1, 1'b1);
        cyc();
        idle_chk(1'b0, 1'b1);

        // redirect held while fetch is not ready
        bus.redir_ready = 1'b0;
        drive(1'b1, 32'h8000_0040, 32'h0C10_0020, NOP, 1'b1, 1'b0);
        q.push_back('{1'b0, 32'h8000_0048});
        rq.push_back(32'h8040_0080);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h8000_0048, 32'h0C10_0030, NOP, 1'b1, 1'b0);
            chk("hold_rv", 32'(bus.redir_valid), 32'd1);
            chk("hold_pc", bus.redir_pc, 32'h8040_0080);
            chk("hold_ready", 32'(bus.in_ready), 32'd0);
            cyc();
        end
        bus.redir_ready = 1'b1;
        chk("release_rv", 32'(bus.redir_valid), 32'd1);
        cyc();
        idle_chk(1'b0, 1'b1);

        // jalr $31,$25: push-only call when enabled, ignored otherwise
        drive(1'b1, 32'h8000_0050, 32'h0320_F809, NOP, 1'b1, 1'b0);
`ifdef RAS_DRIVER_JALR_PUSH_EN
        q.push_back('{1'b0, 32'h8000_0058});
`endif
        cyc();
        idle_chk(1'b0, 1'b1);
        drive(1'b1, 32'h8000_0060, 32'h0C10_0030, NOP, 1'b1, 1'b0);
        q.push_back('{1'b0, 32'h8000_0068});
        rq.push_back(32'h8040_00C0);
        cyc();
        idle_chk(1'b1, 1'b0);
        idle_chk(1'b0, 1'b1);

        chk("events_left", 32'(q.size()), 32'd0);
        chk("redirs_left", 32'(rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
